// File: rtl/mant_div11.sv
// Iterative radix-2 restoring divider for floating-point mantissas.
// Produces floor(a*2^W/b), the remainder and a sticky bit, one quotient bit per cycle.
module mant_div11 #(
    parameter int W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   q,
    output logic [W-1:0]     r,
    output logic             sticky,
    output logic             dz
);

    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0] LAST_STEP = CW'(2*W-1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [2*W-1:0]   dvd_r;
    logic [W-1:0]     rem_r;
    logic [W-1:0]     b_r;
    logic [CW-1:0]    cnt_r;
    logic [2*W-1:0]   q_r;
    logic [W-1:0]     r_r;
    logic             sticky_r;
    logic             dz_r;
    logic             out_valid_r;

    logic [W:0]       t_s;
    logic [W:0]       diff_s;
    logic             qbit_s;
    logic [W-1:0]     rem_nxt_s;
    logic [2*W-1:0]   dvd_nxt_s;
    logic             zero_div_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign q         = q_r;
    assign r         = r_r;
    assign sticky    = sticky_r;
    assign dz        = dz_r;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        t_s        = {rem_r, dvd_r[2*W-1]};
        diff_s     = t_s - {1'b0, b_r};
        zero_div_s = (b_r == {W{1'b0}});
        if (t_s >= {1'b0, b_r}) begin
            qbit_s    = 1'b1;
            rem_nxt_s = diff_s[W-1:0];
        end else begin
            qbit_s    = 1'b0;
            rem_nxt_s = t_s[W-1:0];
        end
        dvd_nxt_s = {dvd_r[2*W-2:0], qbit_s};
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            dvd_r       <= {(2*W){1'b0}};
            rem_r       <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            cnt_r       <= {CW{1'b0}};
            q_r         <= {(2*W){1'b0}};
            r_r         <= {W{1'b0}};
            sticky_r    <= 1'b0;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r   <= {a, {W{1'b0}}};
                        rem_r   <= {W{1'b0}};
                        b_r     <= b;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // A zero divisor spends exactly one cycle here and reports the saturated result.
                    if (zero_div_s) begin
                        q_r         <= {(2*W){1'b1}};
                        r_r         <= dvd_r[2*W-1:W];
                        sticky_r    <= (dvd_r[2*W-1:W] != {W{1'b0}});
                        dz_r        <= 1'b1;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        dvd_r <= dvd_nxt_s;
                        rem_r <= rem_nxt_s;
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == LAST_STEP) begin
                            q_r         <= dvd_nxt_s;
                            r_r         <= rem_nxt_s;
                            sticky_r    <= (rem_nxt_s != {W{1'b0}});
                            dz_r        <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mant_div11.sv
// Directed and randomised self-checking bench for mant_div11 (W=11).
module tb_mant_div11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] a;
    logic [10:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] q;
    logic [10:0] r;
    logic        sticky;
    logic        dz;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    mant_div11 #(.W(11)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .r(r), .sticky(sticky), .dz(dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Waits for in_ready, accepts one operand pair, then waits for out_valid.
    task automatic run_op(input logic [10:0] ta, input logic [10:0] tb, output int lat, output int acc_cyc);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b1; a = ta; b = tb;
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0; a = ~ta; b = ~tb;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (!out_valid) $display("FAIL op_timeout a=%h b=%h out_valid=%b required 1", ta, tb, out_valid);
        else n_pass++;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 11'h000; b = 11'h000;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        n_checks++;
        if ({out_valid, q, r, sticky, dz} !== 36'h0) $display("FAIL reset_outputs got %h required 0", {out_valid, q, r, sticky, dz});
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat, acc;
        run_op(11'h400, 11'h400, lat, acc);
        n_checks++;
        if (lat !== 22) $display("FAIL basic_latency got %0d required 22", lat);
        else n_pass++;
        n_checks++;
        if ({q, r, sticky, dz} !== {22'h000800, 11'h000, 1'b0, 1'b0}) $display("FAIL basic_result got q=%h r=%h s=%b dz=%b required q=000800 r=000", q, r, sticky, dz);
        else n_pass++;
        release_result();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_release got ready=%b valid=%b required 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, acc1, acc2;
        out_ready = 1'b1;
        run_op(11'h7FF, 11'h400, lat, acc1);
        n_checks++;
        if ({q, r, sticky, dz} !== {22'h000FFE, 11'h000, 1'b0, 1'b0}) $display("FAIL b2b_first got q=%h r=%h s=%b required q=000FFE r=000 s=0", q, r, sticky);
        else n_pass++;
        run_op(11'h400, 11'h7FF, lat, acc2);
        n_checks++;
        if ({q, r, sticky, dz} !== {22'h000400, 11'h400, 1'b1, 1'b0}) $display("FAIL b2b_second got q=%h r=%h s=%b required q=000400 r=400 s=1", q, r, sticky);
        else n_pass++;
        n_checks++;
        if (acc2 - acc1 !== 24) $display("FAIL b2b_throughput got %0d required 24", acc2 - acc1);
        else n_pass++;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_values();
        int lat, acc;
        run_op(11'h003, 11'h007, lat, acc);
        n_checks++;
        if ({q, r, sticky, dz} !== {22'h00036D, 11'h005, 1'b1, 1'b0}) $display("FAIL small_ratio got q=%h r=%h s=%b required q=00036D r=005 s=1", q, r, sticky);
        else n_pass++;
        release_result();
        run_op(11'h000, 11'h5A5, lat, acc);
        n_checks++;
        if ({q, r, sticky, dz} !== {22'h000000, 11'h000, 1'b0, 1'b0}) $display("FAIL zero_dividend got q=%h r=%h s=%b required 0", q, r, sticky);
        else n_pass++;
        n_checks++;
        if (lat !== 22) $display("FAIL zero_dividend_latency got %0d required 22", lat);
        else n_pass++;
        release_result();
    endtask

    task automatic test_div_zero();
        int lat, acc;
        run_op(11'h123, 11'h000, lat, acc);
        n_checks++;
        if (lat !== 1) $display("FAIL dz_latency got %0d required 1", lat);
        else n_pass++;
        n_checks++;
        if ({q, r, sticky, dz} !== {22'h3FFFFF, 11'h123, 1'b1, 1'b1}) $display("FAIL dz_result got q=%h r=%h s=%b dz=%b required q=3FFFFF r=123 s=1 dz=1", q, r, sticky, dz);
        else n_pass++;
        release_result();
        run_op(11'h7FF, 11'h400, lat, acc);
        n_checks++;
        if ({q, r, sticky, dz} !== {22'h000FFE, 11'h000, 1'b0, 1'b0}) $display("FAIL dz_clear got q=%h r=%h dz=%b required q=000FFE r=000 dz=0", q, r, dz);
        else n_pass++;
        release_result();
    endtask

    task automatic test_backpressure();
        int lat, acc;
        run_op(11'h003, 11'h007, lat, acc);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = 11'h7FF; b = 11'h001;
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, q, r, sticky, dz} !== {1'b1, 1'b0, 22'h00036D, 11'h005, 1'b1, 1'b0})
                $display("FAIL backpressure_hold cycle=%0d got v=%b rdy=%b q=%h r=%h required v=1 rdy=0 q=00036D r=005", i, out_valid, in_ready, q, r);
            else n_pass++;
        end
        in_valid = 1'b0;
        release_result();
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL backpressure_release got ready=%b valid=%b required 1 0", in_ready, out_valid);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) $display("FAIL backpressure_no_phantom got ready=%b valid=%b required 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, acc;
        in_valid = 1'b1; a = 11'h7FF; b = 11'h400;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if ({out_valid, in_ready, q, r} !== {1'b0, 1'b1, 22'h0, 11'h0}) $display("FAIL midreset_state got v=%b rdy=%b q=%h r=%h required v=0 rdy=1 q=0 r=0", out_valid, in_ready, q, r);
        else n_pass++;
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL midreset_no_partial got %b required 0", out_valid);
        else n_pass++;
        run_op(11'h7FF, 11'h7FF, lat, acc);
        n_checks++;
        if ({q, r, sticky, dz, lat} !== {22'h000800, 11'h000, 1'b0, 1'b0, 32'd22}) $display("FAIL midreset_fresh got q=%h r=%h lat=%0d required q=000800 r=000 lat=22", q, r, lat);
        else n_pass++;
        release_result();
    endtask

    task automatic test_random();
        int lat, acc;
        logic [10:0] ra, rb;
        logic [31:0] num, eq, er;
        for (int i = 0; i < 400; i++) begin
            ra = 11'($urandom_range(0, 2047));
            rb = 11'($urandom_range(1, 2047));
            num = {10'd0, ra, 11'd0};
            eq = num / {21'd0, rb};
            er = num % {21'd0, rb};
            run_op(ra, rb, lat, acc);
            n_checks++;
            if ({q, r, sticky, dz} !== {eq[21:0], er[10:0], (er != 32'd0), 1'b0})
                $display("FAIL random a=%h b=%h got q=%h r=%h s=%b dz=%b required q=%h r=%h", ra, rb, q, r, sticky, dz, eq[21:0], er[10:0]);
            else n_pass++;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_values();
        test_div_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
